delta_event_serializer: RTL and testbench
=========================================

// Module: delta_event_serializer
// PURPOSE
//  Downstream of the delta LIF neuron: takes its gated difference byte (non-zero = spike event),
//  stamps each event with a free-running 8-bit timestamp and queues it in a small FIFO.
//  Drains the queue as 2-byte frames {ts, diff} over an 8-bit valid/ready byte stream,
//  so bursts of spikes survive a slow off-chip reader.
// PARAMETERS
//  DEPTH      8   FIFO entries; power of two, >= 2
//  LVL_W      4   width of fifo_level = $clog2(DEPTH)+1
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  evt_diff    in   8      gated neuron difference; != 0 means event this cycle
//  clr_ovf     in   1      synchronous clear of overflow and drop_cnt
//  out_byte    out  8      stream data: timestamp byte, then diff byte
//  out_valid   out  1      out_byte valid
//  out_last    out  1      high with the diff (2nd) byte of a frame
//  out_ready   in   1      consumer accepts byte when out_valid & out_ready
//  overflow    out  1      sticky: an event was dropped
//  drop_cnt    out  8      dropped-event count, saturates at 255
//  fifo_level  out  LVL_W  entries currently in FIFO (excludes frame being sent)
// BEHAVIOUR
//  Reset (async assert, sync release): ts=0, FIFO empty, fifo_level=0, FSM=IDLE,
//   out_valid=0, out_last=0, out_byte=0, overflow=0, drop_cnt=0; in-flight frames lost.
//  Timestamp: ts +1 every cycle, 255->0 wrap; an event sampled in cycle N takes ts of cycle N.
//  Push: evt_diff!=0 and fifo_level<DEPTH -> write {ts,evt_diff}; fifo_level updates next cycle.
//  Full: evt_diff!=0 with fifo_level==DEPTH -> drop even if a pop occurs the same cycle;
//   overflow<=1, drop_cnt<=sat(drop_cnt+1). clr_ovf and a drop in the same cycle: drop wins
//   (overflow=1, drop_cnt=1).
//  Simultaneous push+pop when not full: both happen, level unchanged.
//  FSM (registered outputs from a holding register):
//   IDLE : out_valid=0. If fifo_level>0: pop into hold reg -> SEND_TS.
//   SEND_TS : out_valid=1, out_byte=hold.ts, out_last=0; on out_ready -> SEND_DIFF.
//   SEND_DIFF: out_valid=1, out_byte=hold.diff, out_last=1; on out_ready:
//     fifo_level>0 -> pop, -> SEND_TS (no idle gap); else -> IDLE.
//  Latency: event in cycle N into empty system -> out_valid=1 with ts byte in cycle N+2.
//  Stream rules: once out_valid is high, out_byte/out_last are held stable until accepted;
//   out_valid never drops mid-frame; out_ready while out_valid=0 is ignored.
//  Capacity: DEPTH queued + 1 in hold register.
// STRUCTURE
//  Package delta_evt_pkg: TS_W=8, DIFF_W=8, struct evt_t {ts, diff}, enum ser_state_t
//   {IDLE, SEND_TS, SEND_DIFF}.
//  Sub-module delta_evt_fifo: sync FIFO of evt_t (DEPTH, push/pop, level, full/empty),
//   pointer-based, one extra pointer bit; pop on empty/push on full are no-ops.
//  Top holds timestamp counter, drop logic, FSM and hold register.
// TESTING
//  1 reset, out_ready=1, evt_diff=0x0C in cycle with ts=5 -> two cycles later 0x05
//    (last=0), then 0x0C (last=1); then out_valid=0, fifo_level=0.
//  2 as 1 but out_ready=0 for 10 cycles -> out_byte held 0x05, out_valid held 1, no advance;
//    release -> 0x05, 0x0C in order.
//  3 out_ready=0, 10 consecutive events diffs 1..10 -> event 1 in hold, 2..9 in FIFO,
//    fifo_level=8, overflow=1, drop_cnt=1; drain yields diffs 1..9 with ts consecutive.
//  4 evt_diff=0 for 300 cycles (ts wraps) -> out_valid never 1, fifo_level 0, drop_cnt 0.
//  5 out_ready=1, events at ts=255 and ts=0 -> bytes 0xFF,d1,0x00,d2 back-to-back, no gap;
//    clr_ovf after test 3 -> overflow=0, drop_cnt=0.
//  6 rst_n low while in SEND_DIFF with 3 queued -> out_valid=0 immediately, fifo_level=0,
//    after release no stale frames emitted.

Source files
------------

// File: rtl/delta_evt_pkg.sv
// Shared types for the delta event serializer: event record, serializer states
// and a saturating counter helper.
package delta_evt_pkg;

    localparam int TS_W   = 8;
    localparam int DIFF_W = 8;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [DIFF_W-1:0] diff;
    } evt_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND_TS,
        SEND_DIFF
    } ser_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/delta_evt_fifo.sv
// Synchronous FIFO of timestamped events. The pointers carry one extra wrap bit,
// so full and empty are distinguished without a separate counter.
module delta_evt_fifo
    import delta_evt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  evt_t             push_data_i,
    input  logic             pop_i,
    output evt_t             pop_data_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    evt_t        mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = LVL_W'(wr_ptr_q - rd_ptr_q);

    // Requests that cannot be honoured are silently ignored.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // Head entry is presented combinationally so the serializer can load its
    // holding register in the same cycle it issues the pop.
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/delta_event_serializer.sv
// Timestamps non-zero neuron difference bytes, queues them and streams each one
// out as a two-byte {ts, diff} frame over a valid/ready byte interface.
module delta_event_serializer
    import delta_evt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIFF_W-1:0] evt_diff,
    input  logic              clr_ovf,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    output logic [LVL_W-1:0]  fifo_level
);

    logic [TS_W-1:0] ts_q;
    ser_state_t      state_q, state_d;
    evt_t            hold_q, hold_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic [7:0]      drop_base;

    logic            evt_seen;
    logic            drop;
    logic            push;
    logic            pop;
    evt_t            push_data;
    evt_t            fifo_head;
    logic            fifo_full;
    logic            fifo_empty;

    // A full queue drops the event even if a pop frees a slot this cycle.
    assign evt_seen  = (evt_diff != '0);
    assign drop      = evt_seen && fifo_full;
    assign push      = evt_seen && !fifo_full;
    assign push_data = '{ts: ts_q, diff: evt_diff};

    delta_evt_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = fifo_head;
                    state_d = SEND_TS;
                end
            end
            SEND_TS: begin
                if (out_ready) begin
                    state_d = SEND_DIFF;
                end
            end
            SEND_DIFF: begin
                // Chain straight into the next frame so bursts leave without gaps.
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        hold_d  = fifo_head;
                        state_d = SEND_TS;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A clear and a drop in the same cycle leave one counted drop behind.
    always_comb begin
        drop_base  = clr_ovf ? 8'd0 : drop_cnt_q;
        drop_cnt_d = drop ? sat_inc8(drop_base) : drop_base;
        overflow_d = drop || (overflow_q && !clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            state_q    <= IDLE;
            hold_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_q + 1'b1;
            state_q    <= state_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        out_valid = (state_q != IDLE);
        out_last  = (state_q == SEND_DIFF);
        case (state_q)
            SEND_TS:   out_byte = hold_q.ts;
            SEND_DIFF: out_byte = hold_q.diff;
            default:   out_byte = 8'h00;
        endcase
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_delta_event_serializer.sv
// Directed and random bench for delta_event_serializer against a queue-based
// model of the event stream.
module tb_delta_event_serializer;

    localparam int DEPTH = 8;
    localparam int LVL_W = 4;

    typedef struct packed {
        logic [7:0] ts;
        logic [7:0] diff;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [7:0]       evt_diff = 8'h00;
    logic             clr_ovf = 1'b0;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_last;
    logic             out_ready = 1'b0;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic [LVL_W-1:0] fifo_level;

    int errors = 0;
    int checks = 0;

    // Reference model: queued events, the frame on the wire, bytes left of it.
    ev_t        mq[$];
    ev_t        mframe;
    int         mfb;
    logic [7:0] m_ts;
    logic       m_ovf;
    logic [7:0] m_drop;

    logic [7:0] cap_byte[$];
    int         cap_cyc[$];
    int         cyc;

    delta_event_serializer #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .evt_diff   (evt_diff),
        .clr_ovf    (clr_ovf),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mfb    = 0;
        mframe = '0;
        m_ts   = 8'd0;
        m_ovf  = 1'b0;
        m_drop = 8'd0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        logic       evt, acc, pop, drop;
        int         lvl;
        logic [7:0] base;
        evt  = (evt_diff != 8'h00);
        lvl  = mq.size();
        acc  = (mfb > 0) && out_ready;
        pop  = (lvl > 0) && ((mfb == 0) || (mfb == 1 && out_ready));
        drop = evt && (lvl == DEPTH);
        base = clr_ovf ? 8'd0 : m_drop;
        m_drop = drop ? ((base == 8'hFF) ? base : base + 8'd1) : base;
        m_ovf  = drop || (m_ovf && !clr_ovf);
        if (acc) mfb--;
        if (pop) begin
            mframe = mq.pop_front();
            mfb    = 2;
        end
        if (evt && !drop) mq.push_back({m_ts, evt_diff});
        m_ts = m_ts + 8'd1;
    endtask

    task automatic model_check();
        chk("valid", out_valid, mfb > 0);
        if (mfb > 0) begin
            chk("byte", out_byte, (mfb == 2) ? mframe.ts : mframe.diff);
            chk("last", out_last, mfb == 1);
        end
        chk("level", fifo_level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    // Called at a falling edge: apply inputs, cross one rising edge, check.
    task automatic step(input logic [7:0] d, input logic r, input logic c);
        evt_diff  = d;
        out_ready = r;
        clr_ovf   = c;
        if (out_valid && out_ready) begin
            cap_byte.push_back(out_byte);
            cap_cyc.push_back(cyc);
        end
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        model_check();
    endtask

    task automatic do_reset();
        evt_diff = 8'h00;
        clr_ovf  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid_now", out_valid, 1'b0);
        chk("rst_level_now", fifo_level, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_byte", out_byte, 8'h00);
        chk("rst_last", out_last, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 8'h00);
    endtask

    initial begin
        int n;
        logic [7:0] d;
        cyc = 0;
        model_reset();

        // 1: single event at ts=5, consumer always ready
        do_reset();
        repeat (5) step(8'h00, 1'b1, 1'b0);
        step(8'h0C, 1'b1, 1'b0);
        chk("t1_gap", out_valid, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        chk("t1_ts_byte", out_byte, 8'h05);
        chk("t1_ts_last", out_last, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        chk("t1_diff_byte", out_byte, 8'h0C);
        chk("t1_diff_last", out_last, 1'b1);
        step(8'h00, 1'b1, 1'b0);
        chk("t1_idle_valid", out_valid, 1'b0);
        chk("t1_idle_level", fifo_level, 0);

        // 2: back-pressure holds the timestamp byte
        do_reset();
        repeat (5) step(8'h00, 1'b0, 1'b0);
        step(8'h0C, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(8'h00, 1'b0, 1'b0);
            chk("t2_hold_byte", out_byte, 8'h05);
            chk("t2_hold_valid", out_valid, 1'b1);
        end
        step(8'h00, 1'b1, 1'b0);
        chk("t2_rel_diff", out_byte, 8'h0C);
        step(8'h00, 1'b1, 1'b0);
        chk("t2_rel_idle", out_valid, 1'b0);

        // 3: burst of 10 into a stalled output, one dropped
        do_reset();
        for (int i = 1; i <= 10; i++) step(8'(i), 1'b0, 1'b0);
        chk("t3_level", fifo_level, 8);
        chk("t3_overflow", overflow, 1'b1);
        chk("t3_drop_cnt", drop_cnt, 8'd1);
        cap_byte.delete();
        cap_cyc.delete();
        repeat (25) step(8'h00, 1'b1, 1'b0);
        chk("t3_bytes", cap_byte.size(), 18);
        if (cap_byte.size() == 18) begin
            for (int i = 0; i < 9; i++) begin
                chk("t3_diff", cap_byte[2*i+1], i + 1);
                chk("t3_ts", cap_byte[2*i], 8'(cap_byte[0] + 8'(i)));
            end
        end

        // 5a: clear after overflow
        step(8'h00, 1'b1, 1'b1);
        chk("t5_clr_overflow", overflow, 1'b0);
        chk("t5_clr_drop", drop_cnt, 8'd0);

        // 5b: events at ts=255 and ts=0 stream back-to-back
        n = 0;
        while (m_ts != 8'hFF && n < 300) begin
            step(8'h00, 1'b1, 1'b0);
            n++;
        end
        cap_byte.delete();
        cap_cyc.delete();
        step(8'h3A, 1'b1, 1'b0);
        step(8'h7B, 1'b1, 1'b0);
        repeat (6) step(8'h00, 1'b1, 1'b0);
        chk("t5_bytes", cap_byte.size(), 4);
        if (cap_byte.size() == 4) begin
            chk("t5_b0", cap_byte[0], 8'hFF);
            chk("t5_b1", cap_byte[1], 8'h3A);
            chk("t5_b2", cap_byte[2], 8'h00);
            chk("t5_b3", cap_byte[3], 8'h7B);
            chk("t5_nogap", cap_cyc[3] - cap_cyc[0], 3);
        end

        // 4: long idle with timestamp wrap
        do_reset();
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step(8'h00, 1'b1, 1'b0);
            if (out_valid) n++;
        end
        chk("t4_valid_cnt", n, 0);
        chk("t4_level", fifo_level, 0);
        chk("t4_drop", drop_cnt, 8'd0);

        // 6: reset while sending the diff byte with 3 queued
        do_reset();
        step(8'h11, 1'b0, 1'b0);
        step(8'h22, 1'b0, 1'b0);
        step(8'h33, 1'b0, 1'b0);
        step(8'h44, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("t6_in_diff", out_last, 1'b1);
        chk("t6_queued", fifo_level, 3);
        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(8'h00, 1'b1, 1'b0);
            if (out_valid) n++;
        end
        chk("t6_no_stale", n, 0);

        // Random traffic: slow reader first, then mostly-ready reader
        for (int i = 0; i < 800; i++) begin
            d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            step(d, (i < 300) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 40) == 0);
        end
        repeat (30) step(8'h00, 1'b1, 1'b0);
        chk("rand_drained", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
